pipeline_hazard_ctrl: RTL

// Sequences the 5-stage MIPS pipeline registers (PC, IF_ID, ID_EXE, EXE_MEM): decides per cycle

---
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, branch flushes, MULT/DIV EXE hold.
// Optional STALL_COUNTERS_EN macro adds saturating stall/flush/MDU performance counters.
module pipeline_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_reg_address_rs,
    input  logic [4:0]       ID_reg_address_rt,
    input  logic             id_uses_rt,
    input  logic             EXE_mem_read,
    input  logic [4:0]       EXE_reg_address_rt,
    input  logic             id_branch_taken,
    input  logic             exe_mdu_start,
`ifdef STALL_COUNTERS_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mdu_cycles,
`endif
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EXE_write,
    output logic             ID_EXE_bubble,
    output logic             EXE_MEM_bubble,
    output logic             mdu_busy,
    output logic             mdu_done
);

    localparam int CW = $clog2(MDU_LATENCY + 1);

    typedef enum logic {RUN, MDU_BUSY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          load_use;

    assign load_use = EXE_mem_read && (EXE_reg_address_rt != 5'd0) &&
                      ((EXE_reg_address_rt == ID_reg_address_rs) ||
                       (id_uses_rt && (EXE_reg_address_rt == ID_reg_address_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The start cycle already counts as MDU cycle 1, so the counter is loaded with LATENCY-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (exe_mdu_start) begin
                    state_next = MDU_BUSY;
                    cnt_next   = CW'(MDU_LATENCY - 1);
                end
            end
            MDU_BUSY: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_write       = 1'b0;
        IF_ID_write    = 1'b0;
        IF_ID_flush    = 1'b0;
        ID_EXE_write   = 1'b0;
        ID_EXE_bubble  = 1'b0;
        EXE_MEM_bubble = 1'b0;
        mdu_busy       = 1'b0;
        mdu_done       = 1'b0;
        if (!rst) begin
            if (state == MDU_BUSY) begin
                mdu_busy = 1'b1;
                if (cnt == CW'(1)) begin
                    mdu_done = 1'b1;
                end else begin
                    EXE_MEM_bubble = 1'b1;
                end
            end else if (exe_mdu_start) begin
                EXE_MEM_bubble = 1'b1;
            end else if (load_use) begin
                ID_EXE_write  = 1'b1;
                ID_EXE_bubble = 1'b1;
            end else begin
                pc_write     = 1'b1;
                IF_ID_write  = 1'b1;
                ID_EXE_write = 1'b1;
                IF_ID_flush  = id_branch_taken;
            end
        end
    end

`ifdef STALL_COUNTERS_EN
    logic mdu_hold;

    assign mdu_hold = !rst && ((state == MDU_BUSY) || exe_mdu_start);

    // Bubble into ID_EXE only ever happens on a load-use stall, so it doubles as the stall event.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            mdu_cycles   <= '0;
        end else begin
            if (ID_EXE_bubble && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (IF_ID_flush && !(&flush_count))    flush_count  <= flush_count + CNT_W'(1);
            if (mdu_hold && !(&mdu_cycles))        mdu_cycles   <= mdu_cycles + CNT_W'(1);
        end
    end
`endif

endmodule
